// File: rtl/uart_tx_flow.sv
// uart_tx_flow: byte-wide UART transmitter (8N1, LSB first) with a small
// first-word-fall-through FIFO in front and RTS (active-low clear-to-send)
// flow control sampled only at frame boundaries.
//
// Parameters
//   CLKS_PER_BIT  sys_clk cycles per UART bit (2..65535)
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   sys_clk    in   single clock for all logic
//   rst        in   asynchronous active-high reset
//   TxD_par    in   [7:0] byte to queue
//   TxD_start  in   write strobe, accepted when TxD_ready=1
//   TxD_ready  out  FIFO not full
//   RTS        in   clear-to-send, active-low, asynchronous
//   TX         out  serial line, idle high, driven from a flop
//   tx_busy    out  high while a frame is being shifted out
//   overflow   out  sticky: a write was attempted while the FIFO was full
module uart_tx_flow #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] TxD_par,
  input  logic       TxD_start,
  output logic       TxD_ready,
  input  logic       RTS,
  output logic       TX,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = 16;
  localparam int unsigned IW    = 3;

  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      FULL_CNT  = CW'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [IW-1:0]      LAST_BIT  = IW'(7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;

  logic               rts_meta_q;
  logic               rts_s_q;

  state_t             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [IW-1:0]      bit_idx_q, bit_idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic               wr_en_c;
  logic               pop_c;
  logic               can_start_c;
  logic               baud_last_c;
  logic [7:0]         head_c;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  assign wr_en_c = TxD_start && ready_q;
  assign head_c  = mem[rd_ptr_q];

  // Pointer/occupancy update; a simultaneous write and pop leaves count as is.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (TxD_start && !ready_q) begin
      overflow_d = 1'b1;
    end

    ready_d = (count_d != FULL_CNT);
  end

  // Data array carries no reset: contents are only visible through count.
  always_ff @(posedge sys_clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= TxD_par;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // RTS synchronizer; resets to "blocked" so nothing starts until two
  // edges have seen RTS low.
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rts_meta_q <= 1'b1;
      rts_s_q    <= 1'b1;
    end else begin
      rts_meta_q <= RTS;
      rts_s_q    <= rts_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  // RTS is only consulted here, i.e. when a new frame could begin.
  assign can_start_c = (count_q != '0) && !rts_s_q;
  assign baud_last_c = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    baud_d    = baud_q;
    busy_d    = busy_q;
    pop_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_start_c) begin
          pop_c   = 1'b1;
          shreg_d = head_c;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (baud_last_c) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (baud_last_c) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            tx_d      = shreg_q[bit_idx_q + IW'(1)];
          end
        end
      end

      ST_STOP: begin
        if (baud_last_c) begin
          // Chain straight into the next start bit when data is waiting.
          if (can_start_c) begin
            pop_c   = 1'b1;
            shreg_d = head_c;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Baud counter restarts on each state change and at every bit boundary.
    if ((state_q == ST_IDLE) || (state_d != state_q) || baud_last_c) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BW'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign TxD_ready = ready_q;
  assign TX        = tx_q;
  assign tx_busy   = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_flow.sv
// Directed bench for uart_tx_flow with CLKS_PER_BIT=4, FIFO_AW=2.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_tx_flow;

  localparam int CPB        = 4;
  localparam int FRAME_CLKS = 10 * CPB;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [7:0] TxD_par;
  logic       TxD_start;
  logic       TxD_ready;
  logic       RTS;
  logic       TX;
  logic       tx_busy;
  logic       overflow;

  uart_tx_flow #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (2)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .TxD_par  (TxD_par),
    .TxD_start(TxD_start),
    .TxD_ready(TxD_ready),
    .RTS      (RTS),
    .TX       (TX),
    .tx_busy  (tx_busy),
    .overflow (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // frame[0] = start bit, frame[9] = stop bit
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] exp_q [8];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    TxD_par   = b;
    TxD_start = 1'b1;
    step(1);
    TxD_start = 1'b0;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Checks nfr consecutive frames from exp_q, starting at cycle c0 of the
  // first frame; optionally raises RTS right after cycle rts_at.
  task automatic check_stream(input int nfr, input int c0, input int rts_at, input string tag);
    logic [9:0] fr;
    for (int c = c0; c < nfr * FRAME_CLKS; c++) begin
      fr = frame_of(exp_q[c / FRAME_CLKS]);
      check($sformatf("%s tx f%0d c%0d", tag, c / FRAME_CLKS, c % FRAME_CLKS),
            32'(TX), 32'(fr[(c % FRAME_CLKS) / CPB]));
      check($sformatf("%s busy f%0d c%0d", tag, c / FRAME_CLKS, c % FRAME_CLKS),
            32'(tx_busy), 32'd1);
      if (c == rts_at) RTS = 1'b1;
      step(1);
    end
    check($sformatf("%s end busy", tag), 32'(tx_busy), 32'd0);
    check($sformatf("%s end tx", tag), 32'(TX), 32'd1);
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s idle tx c%0d", tag, c), 32'(TX), 32'd1);
      check($sformatf("%s idle busy c%0d", tag, c), 32'(tx_busy), 32'd0);
      step(1);
    end
  endtask

  initial begin
    tbl[0] = '{8'hA5, 10'b1_1010_0101_0};
    tbl[1] = '{8'h00, 10'b1_0000_0000_0};
    tbl[2] = '{8'hFF, 10'b1_1111_1111_0};
    tbl[3] = '{8'h01, 10'b1_0000_0001_0};
    tbl[4] = '{8'h80, 10'b1_1000_0000_0};
    tbl[5] = '{8'h6B, 10'b1_0110_1011_0};

    rst       = 1'b1;
    RTS       = 1'b1;
    TxD_start = 1'b0;
    TxD_par   = 8'h00;
    step(2);

    // Reset values
    check("rst tx",       32'(TX),        32'd1);
    check("rst busy",     32'(tx_busy),   32'd0);
    check("rst ready",    32'(TxD_ready), 32'd1);
    check("rst overflow", 32'(overflow),  32'd0);

    rst = 1'b0;
    RTS = 1'b0;
    step(4);

    // Single frames from the table; TX falls one edge after the write.
    for (int i = 0; i < 6; i++) begin
      write_byte(tbl[i].data);
      step(1);
      for (int c = 0; c < FRAME_CLKS; c++) begin
        check($sformatf("tbl%0d tx c%0d", i, c), 32'(TX), 32'(tbl[i].frame[c / CPB]));
        check($sformatf("tbl%0d busy c%0d", i, c), 32'(tx_busy), 32'd1);
        step(1);
      end
      check($sformatf("tbl%0d end busy", i), 32'(tx_busy), 32'd0);
      check($sformatf("tbl%0d end tx", i), 32'(TX), 32'd1);
      step(2);
    end

    // Three writes on consecutive edges -> three frames with no gap.
    exp_q[0] = 8'h55; exp_q[1] = 8'h0F; exp_q[2] = 8'hFF;
    TxD_start = 1'b1;
    TxD_par = 8'h55; step(1);
    TxD_par = 8'h0F; step(1);
    TxD_par = 8'hFF; step(1);
    TxD_start = 1'b0;
    check_stream(3, 1, -1, "b2b");
    check_idle(3, "b2b");

    // RTS raised during bit3: frame completes, queued byte waits.
    exp_q[0] = 8'h3C;
    TxD_start = 1'b1;
    TxD_par = 8'h3C; step(1);
    TxD_par = 8'h7E; step(1);
    TxD_start = 1'b0;
    check_stream(1, 0, 16, "rtsmid");
    check_idle(12, "rtshold");
    RTS = 1'b0;
    step(2);
    check("resume sync tx", 32'(TX), 32'd1);
    step(1);
    exp_q[0] = 8'h7E;
    check_stream(1, 0, -1, "resume");
    step(2);

    // Overflow with RTS blocked, then drain exactly four frames.
    RTS = 1'b1;
    step(3);
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    for (int i = 0; i < 5; i++) begin
      TxD_par   = (i < 4) ? exp_q[i] : 8'h99;
      TxD_start = 1'b1;
      step(1);
      check($sformatf("ovf ready w%0d", i), 32'(TxD_ready), (i < 3) ? 32'd1 : 32'd0);
      check($sformatf("ovf flag w%0d", i), 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
    end
    TxD_start = 1'b0;
    check_idle(4, "ovf blocked");
    RTS = 1'b0;
    step(2);
    check("drain sync tx", 32'(TX), 32'd1);
    step(1);
    check_stream(4, 0, -1, "drain");
    check_idle(20, "drain");
    check("drain overflow sticky", 32'(overflow), 32'd1);
    check("drain ready", 32'(TxD_ready), 32'd1);

    // Reset during data bit4 with a second byte queued.
    write_byte(8'hC3);
    TxD_par   = 8'h5A;
    TxD_start = 1'b1;
    step(1);
    TxD_start = 1'b0;
    step(21);
    check("prerst tx bit4", 32'(TX), 32'd0);
    check("prerst busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst tx",       32'(TX),        32'd1);
    check("async rst busy",     32'(tx_busy),   32'd0);
    check("async rst ready",    32'(TxD_ready), 32'd1);
    check("async rst overflow", 32'(overflow),  32'd0);
    step(2);
    rst = 1'b0;
    check_idle(15, "postrst");
    exp_q[0] = 8'h96;
    write_byte(8'h96);
    step(1);
    check_stream(1, 0, -1, "postrst");
    step(2);

    // Write and frame-start pop on the same edge with three queued.
    RTS = 1'b1;
    step(3);
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    check("simul ready pre", 32'(TxD_ready), 32'd1);
    RTS = 1'b0;
    step(2);
    TxD_par   = 8'hD4;
    TxD_start = 1'b1;
    step(1);
    check("simul start tx", 32'(TX), 32'd0);
    check("simul occ3 ready", 32'(TxD_ready), 32'd1);
    TxD_par = 8'hE5;
    step(1);
    TxD_start = 1'b0;
    check("simul occ4 ready", 32'(TxD_ready), 32'd0);
    check("simul overflow", 32'(overflow), 32'd0);
    exp_q[0] = 8'hA1; exp_q[1] = 8'hB2; exp_q[2] = 8'hC3;
    exp_q[3] = 8'hD4; exp_q[4] = 8'hE5;
    check_stream(5, 1, -1, "simul");
    check_idle(4, "simul");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
